// File: rtl/ram_pkg.sv
// Shared constants and FSM encoding for the RAM-side read blocks.
// The burst reader and its FIFO take their default widths from here.
package ram_pkg;

    localparam int RAM_DATA_W = 8;
    localparam int RAM_ADDR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } rd_state_e;

endpackage

// File: rtl/rd_fifo2.sv
// Two-entry FIFO with a combinational head output.
// Push and pop may happen in the same cycle at any occupancy.
module rd_fifo2
    import ram_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       do_push;
    logic       do_pop;

    assign empty   = (count_q == 2'd0);
    assign full    = (count_q == 2'd2);
    assign do_pop  = pop & ~empty;
    // When full, a push is only accepted if the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        logic [DATA_W-1:0] entry_q;
        always_ff @(posedge clka) begin
            if (!rst_n) begin
                entry_q <= '0;
            end else if (do_push && (wr_ptr_q == 1'(gi))) begin
                entry_q <= din;
            end
        end
    end

    assign dout = rd_ptr_q ? g_entry[1].entry_q : g_entry[0].entry_q;

    always_ff @(posedge clka) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/ram_reader.sv
// Burst reader: fetches 'length' words from a 1-cycle-latency RAM starting at
// 'base_addr' (wrapping) and streams them out through a 2-entry FIFO.
module ram_reader
    import ram_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready
);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   issue_rem_q, issue_rem_d;
    logic [ADDR_W:0]   accept_rem_q, accept_rem_d;
    logic              inflight_q;

    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic [1:0]        occupancy;
    logic [1:0]        pending;

    rd_fifo2 #(.DATA_W(DATA_W)) u_fifo (
        .clka  (clka),
        .rst_n (rst_n),
        .push  (inflight_q),
        .din   (ram_dout),
        .pop   (pop),
        .dout  (m_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign m_valid   = ~fifo_empty;
    assign pop       = m_valid & m_ready;
    assign occupancy = {fifo_full, ~fifo_empty & ~fifo_full};
    // A word leaving this cycle frees its slot in time for a new issue,
    // which is what sustains one word per cycle with m_ready held high.
    assign pending   = occupancy + {1'b0, inflight_q} - {1'b0, pop};

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        issue_rem_d  = issue_rem_q;
        accept_rem_d = pop ? accept_rem_q - 1'b1 : accept_rem_q;
        ram_en       = 1'b0;
        done         = 1'b0;
        busy         = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d       = base_addr;
                    issue_rem_d  = length;
                    accept_rem_d = length;
                    state_d      = (length == '0) ? ST_FIN : ST_READ;
                end
            end
            ST_READ: begin
                if (pending < 2'd2) begin
                    ram_en      = 1'b1;
                    addr_d      = addr_q + 1'b1;
                    issue_rem_d = issue_rem_q - 1'b1;
                    if (issue_rem_q == (ADDR_W+1)'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && accept_rem_q == (ADDR_W+1)'(1)) state_d = ST_FIN;
            end
            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ram_addr = addr_q;

    always_ff @(posedge clka) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            issue_rem_q  <= '0;
            accept_rem_q <= '0;
            inflight_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            issue_rem_q  <= issue_rem_d;
            accept_rem_q <= accept_rem_d;
            inflight_q   <= ram_en;
        end
    end

endmodule

// File: tb/tb_ram_reader.sv
// Bench for ram_reader: a RAM model, a queue-based burst reference model, and
// directed plus randomized bursts under several m_ready patterns.
module tb_ram_reader;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clka = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic              busy;
    logic              done;
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dout;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;

    always #5 clka = ~clka;

    ram_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clka      (clka),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .ram_en    (ram_en),
        .ram_addr  (ram_addr),
        .ram_dout  (ram_dout),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready)
    );

    logic [DATA_W-1:0] ram_mem [DEPTH];
    always @(posedge clka) begin
        if (ram_en) ram_dout <= ram_mem[ram_addr];
    end

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: expectations for the current cycle.
    bit                mdl_busy = 1'b0;
    bit                mdl_done = 1'b0;
    logic [ADDR_W-1:0] exp_addr_q [$];
    logic [DATA_W-1:0] exp_data_q [$];
    int                burst_left   = 0;
    int                outstanding  = 0;
    int                accept_total = 0;
    int                done_seen    = 0;
    bit                prev_stall   = 1'b0;
    logic [DATA_W-1:0] prev_data    = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Evaluates the cycle about to be clocked and advances the model.
    task automatic monitor();
        bit                nxt_busy;
        bit                nxt_done;
        logic [DATA_W-1:0] want_d;
        logic [ADDR_W-1:0] want_a;
        if (!rst_n) begin
            exp_addr_q.delete();
            exp_data_q.delete();
            mdl_busy    = 1'b0;
            mdl_done    = 1'b0;
            burst_left  = 0;
            outstanding = 0;
            prev_stall  = 1'b0;
            return;
        end
        check("busy", 32'(busy), 32'(mdl_busy));
        check("done", 32'(done), 32'(mdl_done));
        if (done === 1'b1) done_seen++;
        if (prev_stall) begin
            check("stall_valid", 32'(m_valid), 32'd1);
            check("stall_data", 32'(m_data), 32'(prev_data));
        end
        if (m_valid === 1'b1) check("valid_has_word", 32'(exp_data_q.size() > 0), 32'd1);
        nxt_busy = mdl_busy;
        nxt_done = 1'b0;
        if (m_valid === 1'b1 && m_ready && exp_data_q.size() > 0) begin
            want_d = exp_data_q.pop_front();
            check("m_data", 32'(m_data), 32'(want_d));
            outstanding--;
            accept_total++;
            burst_left--;
            if (burst_left == 0) nxt_done = 1'b1;
        end
        if (ram_en === 1'b1) begin
            check("ram_en_expected", 32'(exp_addr_q.size() > 0), 32'd1);
            if (exp_addr_q.size() > 0) begin
                want_a = exp_addr_q.pop_front();
                check("ram_addr", 32'(ram_addr), 32'(want_a));
            end
            outstanding++;
            check("outstanding_le2", 32'(outstanding <= 2), 32'd1);
        end
        if (!mdl_busy && start) begin
            nxt_busy   = 1'b1;
            burst_left = int'(length);
            for (int i = 0; i < int'(length); i++) begin
                want_a = ADDR_W'(int'(base_addr) + i);
                exp_addr_q.push_back(want_a);
                exp_data_q.push_back(ram_mem[want_a]);
            end
            if (length == '0) nxt_done = 1'b1;
        end
        if (mdl_done) nxt_busy = 1'b0;
        prev_stall = (m_valid === 1'b1) && !m_ready;
        prev_data  = m_data;
        mdl_busy   = nxt_busy;
        mdl_done   = nxt_done;
    endtask

    task automatic step();
        @(negedge clka);
        monitor();
        @(posedge clka);
        #1;
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 2 == 0);
        return 1'($urandom_range(0, 1));
    endfunction

    // noise=1 keeps start asserted with other parameters while the burst runs.
    task automatic run_burst(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l,
                             input int mode, input bit noise);
        int cyc;
        base_addr = b;
        length    = l;
        start     = 1'b1;
        m_ready   = ready_for(mode, 0);
        step();
        start = 1'b0;
        cyc   = 0;
        while (mdl_busy && cyc < 300) begin
            if (noise) begin
                start     = 1'b1;
                base_addr = b + 4'd6;
                length    = 5'd1;
            end
            m_ready = ready_for(mode, cyc + 1);
            step();
            cyc++;
        end
        start = 1'b0;
        check("burst_timeout", 32'(cyc < 300), 32'd1);
        check("burst_all_words", 32'(exp_data_q.size()), 32'd0);
        step();
        check("idle_after_burst", 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        int acc0;
        int done0;

        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        m_ready   = 1'b0;
        for (int a = 0; a < DEPTH; a++) ram_mem[a] = DATA_W'(a + 'h10);
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        rst_n = 1'b1;
        step();

        // base 3, length 4, full throughput
        m_ready   = 1'b1;
        base_addr = 4'd3;
        length    = 5'd4;
        start     = 1'b1;
        step();
        start = 1'b0;
        check("lat_valid_c1", 32'(m_valid), 32'd0);
        step();
        check("lat_valid_c2", 32'(m_valid), 32'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            check("tput_valid", 32'(m_valid), 32'd1);
            check("tput_data", 32'(m_data), 32'('h13 + i));
            step();
        end
        check("done_after_last", 32'(done), 32'd1);
        step();
        check("busy_low_after", 32'(busy), 32'd0);
        check("done_single", 32'(done), 32'd0);

        // address wrap
        run_burst(4'hE, 5'd3, 0, 1'b0);
        // stalls with 1010 ready pattern
        run_burst(4'd7, 5'd5, 1, 1'b0);
        // zero length
        done0 = done_seen;
        run_burst(4'd5, 5'd0, 0, 1'b0);
        check("zero_len_done_once", 32'(done_seen - done0), 32'd1);

        // reset after 2 of 6 accepted
        done0     = done_seen;
        acc0      = accept_total;
        base_addr = 4'd9;
        length    = 5'd6;
        start     = 1'b1;
        m_ready   = 1'b1;
        step();
        start = 1'b0;
        cyc   = 0;
        while (accept_total - acc0 < 2 && cyc < 50) begin
            m_ready = ready_for(1, cyc);
            step();
            cyc++;
        end
        check("abort_wait", 32'(cyc < 50), 32'd1);
        rst_n = 1'b0;
        step();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_m_valid", 32'(m_valid), 32'd0);
        check("abort_ram_en", 32'(ram_en), 32'd0);
        check("abort_m_data", 32'(m_data), 32'd0);
        rst_n = 1'b1;
        step();
        step();
        check("abort_no_done", 32'(done_seen - done0), 32'd0);
        run_burst(4'd0, 5'd2, 0, 1'b0);

        // start while busy is ignored
        run_burst(4'd2, 5'd6, 2, 1'b1);

        // random bursts over random RAM contents
        for (int a = 0; a < DEPTH; a++) ram_mem[a] = DATA_W'($urandom);
        for (int n = 0; n < 25; n++) begin
            run_burst(ADDR_W'($urandom), (ADDR_W+1)'($urandom_range(0, DEPTH)),
                      int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end
        run_burst(4'd0, 5'd16, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_reader.md
RAM_READER -- requirements
Module: ram_reader

Interface
REQ-001 Parameter DATA_W, default 8: RAM word and stream data width.
REQ-002 Parameter ADDR_W, default 4: RAM address width; the RAM depth is 2^ADDR_W.
REQ-003 clka  in  1: sole clock; all logic samples on the rising edge.
REQ-004 rst_n  in  1: synchronous, active-low reset, sampled on the clka rising edge.
REQ-005 start  in  1: request to begin a burst; honoured only in IDLE.
REQ-006 base_addr  in  ADDR_W: first RAM address read, captured when start is honoured.
REQ-007 length  in  ADDR_W+1: number of words to read (0..2^ADDR_W), captured when start is honoured.
REQ-008 busy  out  1: high in every state except IDLE.
REQ-009 done  out  1: one-cycle pulse when the last word of a burst is accepted downstream.
REQ-010 ram_en  out  1: RAM read enable.
REQ-011 ram_addr  out  ADDR_W: RAM read address.
REQ-012 ram_dout  in  DATA_W: RAM read data, valid exactly 1 cycle after the cycle in which ram_en=1.
REQ-013 m_valid  out  1: stream word available.
REQ-014 m_data  out  DATA_W: stream word.
REQ-015 m_ready  in  1: the downstream accepts a word in any cycle where m_valid & m_ready.

Function
REQ-016 The FSM SHALL have states IDLE, READ, DRAIN and FIN.
REQ-017 IDLE: when start=1, latch base_addr and length. If length=0, go to FIN. Otherwise go to READ.
REQ-018 READ: issue ram_en=1 when (buffered words + in-flight reads) < 2; ram_addr = current address; increment the address and decrement the remaining-issue count on each issue.
REQ-019 The address SHALL wrap modulo 2^ADDR_W (for example, 4'hF then 4'h0).
REQ-020 READ SHALL go to DRAIN in the cycle after the last read is issued.
REQ-021 DRAIN: ram_en=0. Go to FIN in the cycle the last word is accepted.
REQ-022 FIN: lasts 1 cycle, with done=1, then returns to IDLE.
REQ-023 When length=0, FIN SHALL still pulse done, and no read or stream word SHALL occur.
REQ-024 Returned RAM data SHALL be written into a 2-entry FIFO the cycle after issue. m_valid is high when the FIFO is not empty; m_data is the FIFO head.
REQ-025 Words SHALL leave in address order, with no loss or duplication under any m_ready pattern.
REQ-026 The FIFO SHALL never overflow; the issue rule in REQ-018 guarantees this.
REQ-027 A simultaneous FIFO push and pop SHALL be legal in any occupancy state.
REQ-028 With m_ready held at 1, throughput SHALL be 1 word per cycle. The first m_valid appears 2 cycles after start is sampled.
REQ-029 m_valid and m_data SHALL be stable while m_valid=1 and m_ready=0.
REQ-030 start while busy=1 SHALL be ignored and SHALL not alter the captured parameters.
REQ-031 ram_en SHALL be 0 in IDLE, DRAIN and FIN.

Reset
REQ-032 While rst_n=0 at a clka edge, the block SHALL go to IDLE, and all of the following SHALL be 0: address, counters, FIFO pointers, occupancy, busy, done, ram_en, ram_addr and m_valid. m_data SHALL be 0.
REQ-033 Reset mid-burst SHALL abort immediately. RAM data returning the next cycle SHALL be discarded. No done pulse SHALL be produced.

Structure
REQ-034 The state encoding and the default DATA_W/ADDR_W constants SHALL reside in a shared package/include file, ram_pkg, which the RAM-side blocks also use.
REQ-035 The 2-entry FIFO SHALL be a sub-module named rd_fifo2 (ports: clka, rst_n, push, din, pop, dout, empty, full).

Verification
REQ-036 Stimulus: base=3, length=4, m_ready=1, RAM[a]=a+8'h10. Required response: m_data 13,14,15,16 on consecutive cycles; done 1 cycle after the last accept; busy low after that.
REQ-037 Stimulus: base=4'hE, length=3. Required response: ram_addr E,F,0 and the matching data in order.
REQ-038 Stimulus: length=5, m_ready toggles 1010... Required response: 5 words in order; m_data holds while stalled; ram_en never issues a third outstanding word.
REQ-039 Stimulus: length=0. Required response: no ram_en and no m_valid; done pulses once; the block returns to IDLE.
REQ-040 Stimulus: rst_n=0 for 1 cycle after 2 of 6 words have been accepted, then start base=0, length=2. Required response: no done for the aborted burst; only RAM[0] and RAM[1] are streamed.
REQ-041 Stimulus: start asserted during READ with a different base. Required response: ignored; the original burst completes unchanged.
